// File: rtl/apb_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_req_arbiter_if
//  Brief    : Bundles the requester-side handshake and the APB master command
//             port shared through apb_req_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface apb_req_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  // Requester side (packed per requester)
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;

  // APB master command port
  logic                          transfer;
  logic                          READ_WRITE;
  logic [ADDR_WIDTH-1:0]         apb_write_paddr;
  logic [ADDR_WIDTH-1:0]         apb_read_paddr;
  logic [DATA_WIDTH-1:0]         apb_write_data;
  logic [DATA_WIDTH-1:0]         apb_read_data_out;
  logic                          PSLVERR;
  logic                          xfer_done;

  // The arbiter masters the command port towards the APB master.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  apb_read_data_out, PSLVERR, xfer_done,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data
  );

  // Environment view: requesters plus the APB master that executes commands.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output apb_read_data_out, PSLVERR, xfer_done,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data
  );

endinterface : apb_req_arbiter_if
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : apb_req_arbiter
//  Brief    : Round-robin arbiter sharing one APB master command port between
//             NUM_REQ requesters, one transaction in flight at a time.
//             Optional BUSY watchdog enabled by defining APB_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_req_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Reject unsupported configurations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_req_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_last_grant;
  logic [IDX_W-1:0]      r_grant;

  logic                  w_found;
  logic [IDX_W-1:0]      w_gidx;
  logic [IDX_W-1:0]      w_cand;
  logic [NUM_REQ-1:0]    w_ready_vec;
  logic [NUM_REQ-1:0]    w_grant_vec;
  logic                  w_sel_write;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_tmo_hit;
  logic                  w_finish;

  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

  // Unpack the flat requester buses so the winner can be selected by index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first valid requester after the last one served.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = IDX_W'((32'(r_last_grant) + 32'(off)) % 32'(NUM_REQ));
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  assign w_sel_write = bus.req_write[w_gidx];
  assign w_sel_addr  = w_addr_arr[w_gidx];
  assign w_sel_wdata = w_wdata_arr[w_gidx];

  // Accept strobe exists only while idle, and only for the winner.
  assign w_ready_vec   = NUM_REQ'(1) << w_gidx;
  assign bus.req_ready = (r_state == IDLE && w_found) ? w_ready_vec : '0;

  assign w_grant_vec = NUM_REQ'(1) << r_grant;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  // Watchdog: counts BUSY cycles; expiry is the last BUSY cycle allowed.
  always_ff @(posedge PCLK) begin
    if (PRESET || r_state != BUSY) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo_hit = (r_state == BUSY) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Normal completion wins over a simultaneous watchdog expiry.
  assign w_finish = bus.xfer_done || w_tmo_hit;

  // Arbitration FSM with registered command and response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state             <= IDLE;
      r_last_grant        <= IDX_W'(NUM_REQ - 1);
      r_grant             <= '0;
      bus.transfer        <= 1'b0;
      bus.READ_WRITE      <= 1'b0;
      bus.apb_write_paddr <= '0;
      bus.apb_read_paddr  <= '0;
      bus.apb_write_data  <= '0;
      bus.rsp_valid       <= '0;
      bus.rsp_rdata       <= '0;
      bus.rsp_err         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant        <= w_gidx;
            bus.transfer   <= 1'b1;
            bus.READ_WRITE <= w_sel_write;
            if (w_sel_write) begin
              bus.apb_write_paddr <= w_sel_addr;
              bus.apb_write_data  <= w_sel_wdata;
              bus.apb_read_paddr  <= '0;
            end else begin
              bus.apb_write_paddr <= '0;
              bus.apb_write_data  <= '0;
              bus.apb_read_paddr  <= w_sel_addr;
            end
            r_state <= BUSY;
          end
        end

        BUSY: begin
          if (w_finish) begin
            bus.transfer        <= 1'b0;
            bus.READ_WRITE      <= 1'b0;
            bus.apb_write_paddr <= '0;
            bus.apb_read_paddr  <= '0;
            bus.apb_write_data  <= '0;
            bus.rsp_valid       <= w_grant_vec;
            // Timeout completes as an error with no data.
            bus.rsp_err         <= bus.xfer_done ? bus.PSLVERR : 1'b1;
            bus.rsp_rdata       <= (bus.xfer_done && !bus.READ_WRITE) ?
                                   bus.apb_read_data_out : '0;
            r_state             <= RESP;
          end
        end

        RESP: begin
          bus.rsp_valid <= '0;
          r_last_grant  <= r_grant;
          r_state       <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : apb_req_arbiter
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_req_arbiter
//  Brief    : Directed self-checking bench for apb_req_arbiter.
//             Timeout steps are included when APB_ARB_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic PCLK = 1'b0;
  logic PRESET;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_g;

  apb_req_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_req_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  // 100 MHz-style free-running clock
  always #5 PCLK = ~PCLK;

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req_write[i]            = wr;
    bus.req_addr[i*AW +: AW]    = a;
    bus.req_wdata[i*DW +: DW]   = d;
  endtask

  // Directed sequence
  initial begin
    bus.req_valid         = '0;
    bus.req_write         = '0;
    bus.req_addr          = '0;
    bus.req_wdata         = '0;
    bus.apb_read_data_out = '0;
    bus.PSLVERR           = 1'b0;
    bus.xfer_done         = 1'b0;
    PRESET                = 1'b1;
    tick;
    tick;
    chk("rst_transfer",  bus.transfer,   0);
    chk("rst_rsp_valid", bus.rsp_valid,  0);
    chk("rst_rsp_err",   bus.rsp_err,    0);
    chk("rst_rsp_rdata", bus.rsp_rdata,  0);
    chk("rst_rw",        bus.READ_WRITE, 0);
    chk("rst_ready",     bus.req_ready,  0);
    PRESET = 1'b0;
    tick;

    // ---- write from requester 0, done 3 cycles after transfer rises
    set_req(0, 1'b1, 8'h12, 8'hA5);
    bus.req_valid = 4'b0001;
    #1;
    chk("wr_ready", bus.req_ready, 4'b0001);
    tick;
    chk("wr_transfer", bus.transfer,        1);
    chk("wr_rw",       bus.READ_WRITE,      1);
    chk("wr_waddr",    bus.apb_write_paddr, 8'h12);
    chk("wr_wdata",    bus.apb_write_data,  8'hA5);
    chk("wr_raddr",    bus.apb_read_paddr,  0);
    chk("wr_busy_rdy", bus.req_ready,       0);
    bus.req_valid = '0;
    tick;
    tick;
    chk("wr_hold_addr", bus.apb_write_paddr, 8'h12);
    tick;
    bus.xfer_done = 1'b1;
    chk("wr_hold_xfer", bus.transfer, 1);
    tick;
    bus.xfer_done = 1'b0;
    chk("wr_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("wr_rsp_err",   bus.rsp_err,   0);
    chk("wr_rsp_rdata", bus.rsp_rdata, 0);
    chk("wr_xfer_drop", bus.transfer,  0);
    tick;
    chk("wr_rsp_1cyc", bus.rsp_valid, 0);

    // ---- xfer_done while idle must be ignored
    bus.PSLVERR           = 1'b1;
    bus.apb_read_data_out = 8'h77;
    bus.xfer_done         = 1'b1;
    tick;
    bus.xfer_done = 1'b0;
    bus.PSLVERR   = 1'b0;
    tick;
    chk("idle_done_rsp",   bus.rsp_valid, 0);
    chk("idle_done_err",   bus.rsp_err,   0);
    chk("idle_done_rdata", bus.rsp_rdata, 0);

    // ---- read from requester 2
    set_req(2, 1'b0, 8'h40, 8'h99);
    bus.req_valid = 4'b0100;
    #1;
    chk("rd_ready", bus.req_ready, 4'b0100);
    tick;
    chk("rd_rw",       bus.READ_WRITE,      0);
    chk("rd_raddr",    bus.apb_read_paddr,  8'h40);
    chk("rd_waddr",    bus.apb_write_paddr, 0);
    chk("rd_wdata",    bus.apb_write_data,  0);
    chk("rd_transfer", bus.transfer,        1);
    bus.req_valid         = '0;
    bus.apb_read_data_out = 8'h3C;
    bus.xfer_done         = 1'b1;
    tick;
    bus.xfer_done         = 1'b0;
    bus.apb_read_data_out = 8'hFF;
    chk("rd_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("rd_rsp_rdata", bus.rsp_rdata, 8'h3C);
    chk("rd_rsp_err",   bus.rsp_err,   0);
    tick;
    chk("rd_rsp_1cyc",  bus.rsp_valid, 0);
    chk("rd_rdata_hld", bus.rsp_rdata, 8'h3C);

    // ---- error read from requester 1
    set_req(1, 1'b0, 8'h55, 8'h00);
    bus.req_valid = 4'b0010;
    #1;
    chk("err_ready", bus.req_ready, 4'b0010);
    tick;
    bus.req_valid         = '0;
    bus.PSLVERR           = 1'b1;
    bus.apb_read_data_out = 8'h5A;
    bus.xfer_done         = 1'b1;
    tick;
    bus.xfer_done = 1'b0;
    bus.PSLVERR   = 1'b0;
    chk("err_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("err_rsp_err",   bus.rsp_err,   1);
    chk("err_rsp_rdata", bus.rsp_rdata, 8'h5A);
    tick;

    // ---- clean write from requester 3 clears the error flag
    set_req(3, 1'b1, 8'h66, 8'h0F);
    bus.req_valid = 4'b1000;
    #1;
    chk("ok_ready", bus.req_ready, 4'b1000);
    tick;
    chk("ok_waddr", bus.apb_write_paddr, 8'h66);
    chk("ok_wdata", bus.apb_write_data,  8'h0F);
    bus.req_valid = '0;
    bus.xfer_done = 1'b1;
    tick;
    bus.xfer_done = 1'b0;
    chk("ok_rsp_valid", bus.rsp_valid, 4'b1000);
    chk("ok_rsp_err",   bus.rsp_err,   0);
    chk("ok_rsp_rdata", bus.rsp_rdata, 0);
    tick;

    // ---- round robin with all requesters held: order 0,1,2,3,0
    PRESET = 1'b1;
    tick;
    PRESET = 1'b0;
    for (int i = 0; i < NR; i++) begin
      set_req(i, 1'b1, 8'(8'h10 + i), 8'(8'h20 + i));
    end
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = k % NR;
      #1;
      chk("rr_ready", bus.req_ready, 32'(1) << exp_g);
      tick;
      chk("rr_transfer", bus.transfer,        1);
      chk("rr_waddr",    bus.apb_write_paddr, 32'(8'h10 + exp_g));
      chk("rr_wdata",    bus.apb_write_data,  32'(8'h20 + exp_g));
      chk("rr_busy_rdy", bus.req_ready,       0);
      bus.xfer_done = 1'b1;
      tick;
      bus.xfer_done = 1'b0;
      chk("rr_rsp_valid", bus.rsp_valid, 32'(1) << exp_g);
      chk("rr_resp_rdy",  bus.req_ready, 0);
      tick;
    end

    // ---- reset while BUSY drops the transaction and restores priority
    bus.req_valid = 4'b1000;
    #1;
    chk("mr_ready", bus.req_ready, 4'b1000);
    tick;
    chk("mr_transfer", bus.transfer, 1);
    PRESET        = 1'b1;
    bus.req_valid = 4'b1001;
    tick;
    PRESET = 1'b0;
    chk("mr_xfer_low",  bus.transfer,        0);
    chk("mr_rsp_valid", bus.rsp_valid,       0);
    chk("mr_rw",        bus.READ_WRITE,      0);
    chk("mr_waddr",     bus.apb_write_paddr, 0);
    chk("mr_rsp_rdata", bus.rsp_rdata,       0);
    chk("mr_prio0",     bus.req_ready,       4'b0001);
    tick;
    chk("mr_new_xfer",  bus.transfer,        1);
    chk("mr_new_addr",  bus.apb_write_paddr, 8'h10);
    chk("mr_no_rsp",    bus.rsp_valid,       0);
    bus.req_valid = '0;
    bus.xfer_done = 1'b1;
    tick;
    bus.xfer_done = 1'b0;
    chk("mr_rsp0", bus.rsp_valid, 4'b0001);
    tick;

`ifdef APB_ARB_TIMEOUT_EN
    // ---- watchdog: read from requester 1 never completes
    set_req(1, 1'b0, 8'h77, 8'h00);
    bus.apb_read_data_out = 8'hC3;
    bus.req_valid         = 4'b0010;
    #1;
    chk("to_ready", bus.req_ready, 4'b0010);
    tick;
    bus.req_valid = '0;
    repeat (15) tick;
    chk("to_xfer_16", bus.transfer,  1);
    chk("to_no_rsp",  bus.rsp_valid, 0);
    tick;
    chk("to_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("to_rsp_err",   bus.rsp_err,   1);
    chk("to_rsp_rdata", bus.rsp_rdata, 0);
    chk("to_xfer_low",  bus.transfer,  0);
    tick;
    chk("to_xfer_after", bus.transfer,  0);
    chk("to_rsp_1cyc",   bus.rsp_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_apb_req_arbiter
`default_nettype wire
